// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: sequences fetch/decode/execute/memory/
// writeback states, drives every datapath select and write enable, and keeps
// a wrapping count of retired instructions.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic [1:0]       pc_src,
  output logic             ext_zero,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur_state;
  state_t nxt_state;
  logic   retiring;

  assign state = cur_state;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state decode plus the flag marking the last state of a legal instruction.
  always_comb begin
    nxt_state = FETCH;
    retiring  = 1'b0;
    case (cur_state)
      FETCH: nxt_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:             nxt_state = MEMADR;
          OP_RTYP:                  nxt_state = EXEC;
          OP_BEQ:                   nxt_state = BEQ;
          OP_ADDI, OP_ANDI, OP_ORI: nxt_state = IMMEX;
          OP_J:                     nxt_state = JUMP;
          default:                  nxt_state = FETCH;
        endcase
      end
      MEMADR: nxt_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nxt_state = MEMWB;
      EXEC:   nxt_state = ALUWB;
      IMMEX:  nxt_state = IMMWB;
      MEMWB, MEMWR, ALUWB, IMMWB, BEQ, JUMP: begin
        nxt_state = FETCH;
        retiring  = 1'b1;
      end
      default: nxt_state = FETCH;
    endcase
  end

  // Moore control outputs; pc_en in BEQ follows zero, and reset masks all write enables.
  always_comb begin
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    pc_src      = 2'b00;
    case (cur_state)
      FETCH: begin
        ir_write    = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        pc_en       = 1'b1;
      end
      DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = zero;
      end
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          OP_ANDI: alu_control = ALU_AND;
          OP_ORI:  alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      IMMWB: reg_write = 1'b1;
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: begin
        pc_en = 1'b0;
      end
    endcase
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  // Immediate extension depends only on the opcode, so it holds in every state.
  always_comb begin
    ext_zero = (op == OP_ANDI) || (op == OP_ORI);
  end

  // Retired-instruction counter, bumped as the final state of an instruction is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (retiring) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: drives whole instructions,
// queues the expected state/controls/count per cycle and compares mid-cycle.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;

  logic        pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic        ext_zero;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        pc_en4, iord4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4, alu_src_a4;
  logic [1:0]  alu_src_b4, pc_src4;
  logic [2:0]  alu_control4;
  logic        ext_zero4;
  logic [3:0]  state4;
  logic [3:0]  retired4;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  mState;
  logic [31:0] mCount;
  int          checks;
  int          errors;
  int          cycleNum;

  multicycle_controller dut32 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .ext_zero(ext_zero), .state(state), .retired(retired)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_en(pc_en4), .iord(iord4), .mem_write(mem_write4), .ir_write(ir_write4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .reg_write(reg_write4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_control(alu_control4),
    .pc_src(pc_src4), .ext_zero(ext_zero4), .state(state4), .retired(retired4)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cycleNum, obs, exp);
    end
  endtask

  // Expected controls, packed as {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,
  // reg_write,alu_src_a,alu_src_b,alu_control,pc_src,ext_zero}.
  function automatic logic [15:0] expCtrl(input logic [3:0] s, input logic [5:0] o,
                                          input logic [5:0] f, input logic z, input logic r);
    logic [15:0] c;
    logic [2:0]  fnAlu;
    logic [2:0]  imAlu;
    fnAlu = (f == 6'b100010) ? 3'b110 :
            (f == 6'b100100) ? 3'b000 :
            (f == 6'b100101) ? 3'b001 :
            (f == 6'b101010) ? 3'b111 : 3'b010;
    imAlu = (o == 6'b001100) ? 3'b000 :
            (o == 6'b001101) ? 3'b001 : 3'b010;
    case (s)
      4'd0:    c = {8'b1001_0000, 2'b01, 3'b010, 2'b00, 1'b0};
      4'd1:    c = {8'b0000_0000, 2'b11, 3'b010, 2'b00, 1'b0};
      4'd2:    c = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 1'b0};
      4'd3:    c = {8'b0100_0000, 2'b00, 3'b000, 2'b00, 1'b0};
      4'd4:    c = {8'b0000_0110, 2'b00, 3'b000, 2'b00, 1'b0};
      4'd5:    c = {8'b0110_0000, 2'b00, 3'b000, 2'b00, 1'b0};
      4'd6:    c = {8'b0000_0001, 2'b00, fnAlu,  2'b00, 1'b0};
      4'd7:    c = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 1'b0};
      4'd8:    c = {z, 7'b000_0001, 2'b00, 3'b110, 2'b01, 1'b0};
      4'd9:    c = {8'b0000_0001, 2'b10, imAlu,  2'b00, 1'b0};
      4'd10:   c = {8'b0000_0010, 2'b00, 3'b000, 2'b00, 1'b0};
      4'd11:   c = {8'b1000_0000, 2'b00, 3'b000, 2'b10, 1'b0};
      default: c = 16'h0000;
    endcase
    if (r) begin
      c[15] = 1'b0;
      c[13] = 1'b0;
      c[12] = 1'b0;
      c[9]  = 1'b0;
    end
    c[0] = (o == 6'b001100) || (o == 6'b001101);
    return c;
  endfunction

  // One clock cycle: drive inputs at the falling edge, queue expectations, advance the model.
  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic [3:0] nxtSt, input logic ret);
    exp_t e;
    @(negedge clk);
    reset = r;
    op    = o;
    funct = f;
    zero  = z;
    e.st   = mState;
    e.ctrl = expCtrl(mState, o, f, z, r);
    e.cnt  = mCount;
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      mState = 4'd0;
      mCount = 32'd0;
    end else begin
      if (ret) mCount = mCount + 32'd1;
      mState = nxtSt;
    end
  endtask

  // Runs one instruction through its architectural state sequence; abortAt >= 0 asserts
  // reset during that step instead of completing it.
  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z, input int abortAt);
    logic [3:0] seq[$];
    logic       legal;
    legal = 1'b1;
    case (o)
      6'b100011:                       seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011:                       seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000000:                       seq = '{4'd0, 4'd1, 4'd6, 4'd7};
      6'b000100:                       seq = '{4'd0, 4'd1, 4'd8};
      6'b001000, 6'b001100, 6'b001101: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
      6'b000010:                       seq = '{4'd0, 4'd1, 4'd11};
      default: begin
        seq   = '{4'd0, 4'd1};
        legal = 1'b0;
      end
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abortAt) begin
        applyStimulus(1'b1, o, f, z, 4'd0, 1'b0);
        return;
      end
      if (i == seq.size() - 1) begin
        applyStimulus(1'b0, o, f, z, 4'd0, legal);
      end else begin
        applyStimulus(1'b0, o, f, z, seq[i+1], 1'b0);
      end
    end
  endtask

  // Monitor: just before each rising edge, pop the expectation for this cycle and compare.
  initial begin
    exp_t e;
    cycleNum = 0;
    forever begin
      @(negedge clk);
      #4;
      cycleNum++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("state", {28'd0, state}, {28'd0, e.st});
        checkOutput("ctrl", {16'd0, pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                             reg_write, alu_src_a, alu_src_b, alu_control, pc_src, ext_zero},
                    {16'd0, e.ctrl});
        checkOutput("retired", retired, e.cnt);
        checkOutput("retired4", {28'd0, retired4}, {28'd0, e.cnt[3:0]});
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    op     = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b0;
    mState = 4'd0;
    mCount = 32'd0;
    $display("[TB] starting multicycle_controller bench");
    @(posedge clk);
    @(posedge clk);

    // Reset state check while reset is still held.
    applyStimulus(1'b1, 6'b000000, 6'b000000, 1'b0, 4'd0, 1'b0);

    runInstr(6'b100011, 6'b000000, 1'b0, -1);   // lw
    runInstr(6'b101011, 6'b000000, 1'b1, -1);   // sw
    runInstr(6'b000000, 6'b100000, 1'b0, -1);   // add
    runInstr(6'b000000, 6'b100010, 1'b1, -1);   // sub
    runInstr(6'b000000, 6'b100100, 1'b0, -1);   // and
    runInstr(6'b000000, 6'b100101, 1'b0, -1);   // or
    runInstr(6'b000000, 6'b101010, 1'b0, -1);   // slt
    runInstr(6'b000000, 6'b000111, 1'b0, -1);   // unknown funct -> add
    runInstr(6'b000100, 6'b000000, 1'b1, -1);   // beq taken
    runInstr(6'b000100, 6'b000000, 1'b0, -1);   // beq not taken
    runInstr(6'b001000, 6'b000000, 1'b0, -1);   // addi
    runInstr(6'b001100, 6'b000000, 1'b0, -1);   // andi
    runInstr(6'b001101, 6'b000000, 1'b1, -1);   // ori
    runInstr(6'b000010, 6'b000000, 1'b0, -1);   // j
    runInstr(6'b111111, 6'b000000, 1'b0, -1);   // illegal
    runInstr(6'b000011, 6'b000000, 1'b0, -1);   // illegal (jal not supported)

    // Reset in MEMWR of a store, then a normal fetch after release.
    runInstr(6'b101011, 6'b000000, 1'b0, 3);
    runInstr(6'b001101, 6'b000000, 1'b0, -1);

    // Reset coinciding with a retire edge leaves the count at zero.
    runInstr(6'b000010, 6'b000000, 1'b0, -1);
    runInstr(6'b000010, 6'b000000, 1'b0, 2);
    runInstr(6'b100011, 6'b000000, 1'b0, 3);    // abort lw in MEMRD

    // Sixteen jumps wrap the 4-bit counter back to zero.
    for (int k = 0; k < 16; k++) begin
      runInstr(6'b000010, 6'b000000, k[0], -1);
    end
    runInstr(6'b000000, 6'b100000, 1'b0, -1);

    @(negedge clk);
    @(negedge clk);
    checkOutput("drain", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle MIPS-subset datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. It drives every datapath select and write enable, including the immediate-extension mode applied to the 16-bit immediate field (sign-extend versus zero-extend to 32 bits). It also keeps a 32-bit count of retired instructions.

## Interface

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instruction bits [31:26], taken from the instruction register.
- funct  in  6  instruction bits [5:0], taken from the instruction register.
- zero  in  1  ALU zero flag for the current cycle.
- pc_en  out  1  PC register load.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  data memory write.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data: 0 = ALUOut, 1 = memory data.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- alu_control  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ext_zero  out  1  immediate extension mode: 1 = zero-extend, 0 = sign-extend.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  number of completed instructions.

## Operation

State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, IMMEX=9, IMMWB=10, JUMP=11.

Opcodes:
- lw = 100011, sw = 101011, R-type = 000000, beq = 000100.
- addi = 001000, andi = 001100, ori = 001101, j = 000010.

Transitions:
- FETCH goes to DECODE.
- DECODE:
  - lw or sw goes to MEMADR.
  - R-type goes to EXEC.
  - beq goes to BEQ.
  - addi, andi or ori goes to IMMEX.
  - j goes to JUMP.
  - Any other opcode goes to FETCH; the instruction is not counted as retired.
- MEMADR goes to MEMRD for lw, or to MEMWR for sw.
- MEMRD goes to MEMWB.
- EXEC goes to ALUWB.
- IMMEX goes to IMMWB.
- MEMWB, MEMWR, ALUWB, IMMWB, BEQ and JUMP all go to FETCH.
- Unused encodings 12-15 go to FETCH.

Outputs are Moore functions of state, except pc_en. Signals not listed for a state are 0.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00, pc_en=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=add (computes the branch target).
- MEMADR and IMMEX: alu_src_a=1, alu_src_b=10.
  - IMMEX ALU operation: addi → add, andi → and, ori → or.
  - MEMADR ALU operation: add.
- MEMRD: iord=1.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
- MEMWR: iord=1, mem_write=1.
- EXEC: alu_src_a=1, alu_src_b=00; alu_control decoded from funct:
  - 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - Any other funct → add.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1.
- IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1.
- BEQ: alu_src_a=1, alu_src_b=00, alu_control=sub, pc_src=01, pc_en=zero.
- JUMP: pc_src=10, pc_en=1.

ext_zero:
- Equals 1 when op is andi or ori, in every state. Otherwise 0.
- It is decoded from op alone, so it is valid whenever the instruction register is stable.

retired:
- Increments by 1 (wrapping modulo 2^CNT_W) on the clock edge that leaves MEMWB, MEMWR, ALUWB, IMMWB, BEQ or JUMP.

## Timing

- Instruction latency, from FETCH entry to the next FETCH entry:
  - lw: 5 cycles.
  - sw, R-type, addi, andi, ori: 4 cycles.
  - beq, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- pc_en in BEQ is combinational on zero; no registering of zero is required.
- Reset:
  - While reset=1, pc_en, ir_write, mem_write and reg_write are forced to 0 regardless of state.
  - On a rising edge with reset=1, state becomes FETCH and retired becomes 0.
  - After reset is released, all other outputs take their FETCH values.
  - Reset asserted in any state, including mid-instruction, aborts the instruction with no write and no count.
- A retire edge coinciding with reset=1 leaves retired=0.
- The first fetch begins on the first cycle with reset=0.

## Test plan

- Reset in MEMWR: assert reset in MEMWR with op=101011 (sw) → mem_write=0 during reset; next cycle state=0 and retired=0; after release, ir_write=1 and pc_en=1.
- lw: op=100011 → states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; retired goes from 0 to 1 at the edge leaving state 4.
- R-type with each funct: op=000000, funct=100010 → state 6 has alu_control=110; ALUWB has reg_dst=1.
  - Repeat for 100100 → 000, 100101 → 001, 101010 → 111.
- beq taken and not taken: op=000100 with zero=1 in BEQ → pc_en=1, pc_src=01. Repeat with zero=0 → pc_en=0. Both take 3 cycles and both count as retired.
- Immediate instructions:
  - ori (op=001101) → ext_zero=1 and alu_control=001 in IMMEX.
  - addi (op=001000) → ext_zero=0 and alu_control=010.
  - IMMWB has reg_dst=0.
- Illegal opcode and counter wrap:
  - op=111111 → states 0,1,0 with no write enables and retired unchanged.
  - With CNT_W=4, running 16 j instructions → retired wraps to 0.
